// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: operation codes, FSM states and shift-op range for the sequential ALU
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_ADC   = 4'd2,
        OP_SBC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOT   = 4'd7,
        OP_NAND  = 4'd8,
        OP_NOR   = 4'd9,
        OP_SHL   = 4'd10,
        OP_SHR   = 4'd11,
        OP_ASR   = 4'd12,
        OP_PASSB = 4'd13
    } op_t;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [3:0] OP_SHIFT_FIRST = 4'd10;
    localparam logic [3:0] OP_SHIFT_LAST  = 4'd12;

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one power-of-two shift stage (distance 1<<stage) with the last bit shifted out
module alu_shift_step #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH),
    localparam int IW   = (SHW > 1) ? $clog2(SHW) : 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [IW-1:0]    i_stage,
    input  logic             i_left,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bit
);

    logic [SHW-1:0]          w_dist;
    logic [SHW-1:0]          w_lidx;
    logic [SHW-1:0]          w_ridx;
    logic signed [WIDTH-1:0] w_asr;

    assign w_dist = SHW'(1) << i_stage;
    // WIDTH is a power of two, so WIDTH-dist wraps exactly into SHW bits as -dist
    assign w_lidx = ~w_dist + SHW'(1);
    assign w_ridx = w_dist - SHW'(1);
    assign w_asr  = $signed(i_data) >>> w_dist;

    // select direction and report the bit that falls off the end
    always_comb begin
        o_data = i_left ? (i_data << w_dist) : (i_arith ? w_asr : (i_data >> w_dist));
        o_bit  = i_left ? i_data[w_lidx] : i_data[w_ridx];
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU, single-cycle arith/logic, shifts one power-of-two stage per clock
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_zero_a,
    input  logic             i_sh_b,
    input  logic [SHW-1:0]   i_sh_amt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_flag_z,
    output logic             o_flag_n,
    output logic             o_flag_c,
    output logic             o_flag_v
);

    localparam int IW = (SHW > 1) ? $clog2(SHW) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic             r_left;
    logic             r_arith;

    logic             w_idle;
    logic             w_is_shift;
    logic             w_use_sh;
    logic [WIDTH-1:0] w_step_in;
    logic [SHW-1:0]   w_step_amt;
    logic             w_left;
    logic             w_arith;
    logic [IW-1:0]    w_hi;
    logic [SHW-1:0]   w_rem;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_bit;
    logic [WIDTH-1:0] w_sh_res;
    logic             w_sh_c;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_bx;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [WIDTH-1:0] w_res;

    assign w_idle     = (r_state == IDLE);
    assign w_is_shift = (i_op >= OP_SHIFT_FIRST) && (i_op <= OP_SHIFT_LAST);
    assign w_use_sh   = !w_idle || w_is_shift;

    // in IDLE the first stage works on the live operands, afterwards on the latched ones
    assign w_step_in  = w_idle ? (i_sh_b ? i_b : i_a) : r_data;
    assign w_step_amt = w_idle ? i_sh_amt : r_amt;
    assign w_left     = w_idle ? (i_op == OP_SHL) : r_left;
    assign w_arith    = w_idle ? (i_op == OP_ASR) : r_arith;

    // pick the highest pending stage and the stage bits left after applying it
    always_comb begin
        w_hi = '0;
        for (int k = 0; k < SHW; k++)
            if (w_step_amt[k]) w_hi = IW'(k);
        w_rem    = w_step_amt & ~(SHW'(1) << w_hi);
        w_sh_res = (|w_step_amt) ? w_step_out : w_step_in;
        w_sh_c   = (|w_step_amt) ? w_step_bit : 1'b0;
    end

    alu_shift_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
        .i_data  (w_step_in),
        .i_stage (w_hi),
        .i_left  (w_left),
        .i_arith (w_arith),
        .o_data  (w_step_out),
        .o_bit   (w_step_bit)
    );

    // ZeroA only affects ops 0-3; odd arith ops subtract via inverted B
    assign w_a   = (i_zero_a && i_op[3:2] == 2'b00) ? '0 : i_a;
    assign w_bx  = i_op[0] ? ~i_b : i_b;
    assign w_cin = i_op[1] ? i_cin : i_op[0];
    assign w_sum = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};

    // single-cycle arithmetic and logic; reserved codes fall through to PASSB
    always_comb begin
        w_alu_res = i_b;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (w_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND:  w_alu_res = i_a & i_b;
            OP_OR:   w_alu_res = i_a | i_b;
            OP_XOR:  w_alu_res = i_a ^ i_b;
            OP_NOT:  w_alu_res = ~i_a;
            OP_NAND: w_alu_res = ~(i_a & i_b);
            OP_NOR:  w_alu_res = ~(i_a | i_b);
            default: w_alu_res = i_b;
        endcase
    end

    assign w_res = w_use_sh ? w_sh_res : w_alu_res;

    // control FSM: load/step shifts, commit result and flags, pulse Done
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_amt    <= '0;
            r_left   <= 1'b0;
            r_arith  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_flag_z <= 1'b0;
            o_flag_n <= 1'b0;
            o_flag_c <= 1'b0;
            o_flag_v <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start || !w_idle) begin
                if (w_use_sh && (|w_rem)) begin
                    r_data  <= w_sh_res;
                    r_amt   <= w_rem;
                    r_left  <= w_left;
                    r_arith <= w_arith;
                    o_busy  <= 1'b1;
                    r_state <= SHIFT;
                end else begin
                    o_result <= w_res;
                    o_flag_z <= (w_res == '0);
                    o_flag_n <= w_res[WIDTH-1];
                    o_flag_c <= w_use_sh ? w_sh_c : w_alu_c;
                    o_flag_v <= w_use_sh ? 1'b0 : w_alu_v;
                    o_done   <= 1'b1;
                    o_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            end
        end
    end

endmodule
